// File: rtl/ct_rst_seq_ctrl.sv
// ct_rst_seq_ctrl: reset sequencing controller for the core reset tree.
// After core reset deasserts, the active-low unit resets are released one at
// a time (HAD, MMU, LSU, FPU, IDU, IFU), GAP cycles apart. A debug soft-reset
// request drains the pipeline, re-asserts every unit reset except HAD for
// HOLD cycles, re-sequences the release and pulses rst_soft_ack.
// Optional feature macro: CT_RST_SEQ_TIMEOUT_EN bounds the drain wait to TMO
// cycles and reports an expired drain on rst_soft_tmo.
module ct_rst_seq_ctrl #(
  parameter int GAP  = 4,
  parameter int HOLD = 16,
  parameter int TMO  = 256
) (
  input  logic       forever_coreclk,
  input  logic       core_rst,
  input  logic       pad_yy_scan_mode,
  input  logic       pad_yy_scan_rst_b,
  input  logic       had_soft_rst_req,
  input  logic       core_idle,
  output logic       had_rst_b,
  output logic       mmu_rst_b,
  output logic       lsu_rst_b,
  output logic       fpu_rst_b,
  output logic       idu_rst_b,
  output logic       ifu_rst_b,
  output logic       rst_soft_ack,
  output logic       rst_busy,
  output logic       rst_soft_tmo,
  output logic [2:0] rst_seq_stage
);

  typedef enum logic [2:0] {
    ST_RST,
    ST_RELEASE,
    ST_RUN,
    ST_DRAIN,
    ST_HOLD
  } state_e;

  localparam logic [9:0] GapLast  = 10'(GAP - 1);
  localparam logic [9:0] HoldLast = 10'(HOLD - 1);

  state_e     state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic [2:0] stage_q, stage_d;
  logic [5:0] unitRst_q, unitRst_d;
  logic       ack_q, ack_d;
  logic       busy_q, busy_d;
  logic       soft_q, soft_d;
  logic       armed_q, armed_d;

  logic gapHit;
  logic holdHit;
  logic accept;
  logic drainDone;

  assign gapHit  = (cnt_q == GapLast);
  assign holdHit = (cnt_q == HoldLast);
  // A request only counts once it has been seen low since the last ack.
  assign accept  = had_soft_rst_req && armed_q;

`ifdef CT_RST_SEQ_TIMEOUT_EN
  localparam logic [9:0] TmoLast = 10'(TMO - 1);

  logic tmo_q, tmo_d;
  logic tmoHit;

  assign tmoHit       = (cnt_q == TmoLast);
  assign drainDone    = core_idle || tmoHit;
  assign rst_soft_tmo = tmo_q;
`else
  logic unused_tmo;

  assign unused_tmo   = ^(10'(TMO));
  assign drainDone    = core_idle;
  assign rst_soft_tmo = 1'b0;
`endif

  // State register and all datapath flops; core reset forces everything back
  // to the power-on state immediately, dropping any in-flight ack.
  always_ff @(posedge forever_coreclk or posedge core_rst) begin
    if (core_rst) begin
      state_q   <= ST_RST;
      cnt_q     <= '0;
      stage_q   <= '0;
      unitRst_q <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b1;
      soft_q    <= 1'b0;
      armed_q   <= 1'b0;
`ifdef CT_RST_SEQ_TIMEOUT_EN
      tmo_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      unitRst_q <= unitRst_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      soft_q    <= soft_d;
      armed_q   <= armed_d;
`ifdef CT_RST_SEQ_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  // Next-state logic; the first cycle out of reset already counts toward the
  // HAD release gap, so RST behaves like RELEASE once core reset is low.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RST, ST_RELEASE: begin
        if (gapHit && (stage_q == 3'd5)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      ST_RUN: begin
        if (accept) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drainDone) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (holdHit) begin
          state_d = ST_RELEASE;
        end
      end
      default: state_d = ST_RST;
    endcase
  end

  // Datapath and output next values: gap/hold/drain counter, stage pointer,
  // unit reset flops, soft-sequence tracking and the registered status bits.
  always_comb begin
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    unitRst_d = unitRst_q;
    soft_d    = soft_q;
    ack_d     = 1'b0;
`ifdef CT_RST_SEQ_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    unique case (state_q)
      ST_RST, ST_RELEASE: begin
        if (gapHit) begin
          unitRst_d = unitRst_q | (6'b000001 << stage_q);
          stage_d   = stage_q + 3'd1;
          cnt_d     = '0;
          if ((stage_q == 3'd5) && soft_q) begin
            ack_d  = 1'b1;
            soft_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      ST_RUN: begin
        if (accept) begin
          cnt_d  = '0;
          soft_d = 1'b1;
`ifdef CT_RST_SEQ_TIMEOUT_EN
          tmo_d  = 1'b0;
`endif
        end
      end
      ST_DRAIN: begin
        if (drainDone) begin
          unitRst_d = 6'b000001;
          cnt_d     = '0;
`ifdef CT_RST_SEQ_TIMEOUT_EN
          if (!core_idle) begin
            tmo_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 10'd1;
`endif
        end
      end
      ST_HOLD: begin
        if (holdHit) begin
          stage_d = 3'd1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      default: begin
        cnt_d     = '0;
        stage_d   = '0;
        unitRst_d = '0;
        soft_d    = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_RUN);

    if (ack_d) begin
      armed_d = 1'b0;
    end else if (!had_soft_rst_req) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end
  end

  // Scan mode hands every unit reset straight to the scan reset pin.
  assign had_rst_b = pad_yy_scan_mode ? pad_yy_scan_rst_b : unitRst_q[0];
  assign mmu_rst_b = pad_yy_scan_mode ? pad_yy_scan_rst_b : unitRst_q[1];
  assign lsu_rst_b = pad_yy_scan_mode ? pad_yy_scan_rst_b : unitRst_q[2];
  assign fpu_rst_b = pad_yy_scan_mode ? pad_yy_scan_rst_b : unitRst_q[3];
  assign idu_rst_b = pad_yy_scan_mode ? pad_yy_scan_rst_b : unitRst_q[4];
  assign ifu_rst_b = pad_yy_scan_mode ? pad_yy_scan_rst_b : unitRst_q[5];

  assign rst_soft_ack  = ack_q;
  assign rst_busy      = busy_q;
  assign rst_seq_stage = stage_q;

endmodule

// File: tb/tb_ct_rst_seq_ctrl.sv
// Testbench for ct_rst_seq_ctrl: directed steps with a scoreboard of
// expected output snapshots keyed by edge number after core reset release.
module tb_ct_rst_seq_ctrl;

  localparam int GAP  = 4;
  localparam int HOLD = 16;
  localparam int TMO  = 256;
`ifdef CT_RST_SEQ_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       coreRst;
  logic       scanMode;
  logic       scanRstB;
  logic       softReq;
  logic       coreIdle;
  logic       hadRstB, mmuRstB, lsuRstB, fpuRstB, iduRstB, ifuRstB;
  logic       softAck;
  logic       busy;
  logic       softTmo;
  logic [2:0] seqStage;

  typedef struct {
    string       tag;
    int          cyc;
    logic [11:0] exp;
  } sbEntry_t;

  sbEntry_t sb[$];
  int checks   = 0;
  int errors   = 0;
  int edgeNo   = 0;
  int ackCount = 0;
  int t;
  int h;

  ct_rst_seq_ctrl #(.GAP(GAP), .HOLD(HOLD), .TMO(TMO)) dut (
    .forever_coreclk   (clock),
    .core_rst          (coreRst),
    .pad_yy_scan_mode  (scanMode),
    .pad_yy_scan_rst_b (scanRstB),
    .had_soft_rst_req  (softReq),
    .core_idle         (coreIdle),
    .had_rst_b         (hadRstB),
    .mmu_rst_b         (mmuRstB),
    .lsu_rst_b         (lsuRstB),
    .fpu_rst_b         (fpuRstB),
    .idu_rst_b         (iduRstB),
    .ifu_rst_b         (ifuRstB),
    .rst_soft_ack      (softAck),
    .rst_busy          (busy),
    .rst_soft_tmo      (softTmo),
    .rst_seq_stage     (seqStage)
  );

  // Free-running core clock.
  always #5 clock = ~clock;

  function automatic logic [11:0] mk(input logic [5:0] mask, input logic [2:0] stage,
                                     input logic b, input logic ack, input logic tmo);
    return {tmo, b, ack, stage, mask};
  endfunction

  function automatic logic [11:0] observed();
    return {softTmo, busy, softAck, seqStage,
            ifuRstB, iduRstB, fpuRstB, lsuRstB, mmuRstB, hadRstB};
  endfunction

  task automatic checkOutput(input string tag, input logic [11:0] exp);
    logic [11:0] obs;
    obs = observed();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed tmo/busy/ack/stage/units=%h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkCount(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input string tag, input int cyc, input logic [11:0] exp);
    sb.push_back('{tag, cyc, exp});
  endtask

  task automatic stepEdge();
    sbEntry_t e;
    @(posedge clock);
    edgeNo++;
    @(negedge clock);
    if (softAck === 1'b1) ackCount++;
    while (sb.size() > 0 && sb[0].cyc <= edgeNo) begin
      e = sb.pop_front();
      if (e.cyc == edgeNo) begin
        checkOutput(e.tag, e.exp);
      end else begin
        checkCount({e.tag, "_missed"}, e.cyc, edgeNo);
      end
    end
  endtask

  task automatic advanceTo(input int n);
    while (edgeNo < n) stepEdge();
  endtask

  task automatic pushPowerOn();
    for (int i = 0; i < 6; i++) begin
      pushExp("pwr_pre", (i + 1) * GAP - 1, mk(6'((1 << i) - 1), 3'(i), 1'b1, 1'b0, 1'b0));
      pushExp("pwr_rel", (i + 1) * GAP, mk(6'((1 << (i + 1)) - 1), 3'(i + 1), (i != 5), 1'b0, 1'b0));
    end
  endtask

  task automatic pushSoft(input int hold0, input logic tmoExp);
    pushExp("hold_entry", hold0, mk(6'h01, 3'd6, 1'b1, 1'b0, tmoExp));
    pushExp("hold_end", hold0 + HOLD - 1, mk(6'h01, 3'd6, 1'b1, 1'b0, tmoExp));
    pushExp("rel_entry", hold0 + HOLD, mk(6'h01, 3'd1, 1'b1, 1'b0, tmoExp));
    for (int i = 1; i < 6; i++) begin
      pushExp("soft_pre", hold0 + HOLD + i * GAP - 1,
              mk(6'((1 << i) - 1), 3'(i), 1'b1, 1'b0, tmoExp));
      pushExp("soft_rel", hold0 + HOLD + i * GAP,
              mk(6'((1 << (i + 1)) - 1), 3'(i + 1), (i != 5), (i == 5), tmoExp));
    end
    pushExp("ack_gone", hold0 + HOLD + 5 * GAP + 1, mk(6'h3f, 3'd6, 1'b0, 1'b0, tmoExp));
  endtask

  // Directed sequence: power-on, soft resets, held request, drain timeout,
  // core reset aborts and scan bypass.
  initial begin
    coreRst  = 1'b1;
    scanMode = 1'b0;
    scanRstB = 1'b1;
    softReq  = 1'b0;
    coreIdle = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("reset_state", mk(6'h00, 3'd0, 1'b1, 1'b0, 1'b0));

    coreRst = 1'b0;
    edgeNo  = 0;
    pushPowerOn();
    advanceTo(30);
    checkCount("poweron_no_ack", ackCount, 0);

    t = edgeNo + 1;
    softReq = 1'b1;
    pushExp("drain_entry", t, mk(6'h3f, 3'd6, 1'b1, 1'b0, 1'b0));
    pushSoft(t + 1, 1'b0);
    advanceTo(t + 1 + HOLD + 5 * GAP + 1);
    checkCount("soft_ack_count", ackCount, 1);

    advanceTo(t + 1 + HOLD + 5 * GAP + 100);
    checkOutput("held_run", mk(6'h3f, 3'd6, 1'b0, 1'b0, 1'b0));
    checkCount("held_no_retrigger", ackCount, 1);

    softReq = 1'b0;
    stepEdge();
    stepEdge();
    softReq = 1'b1;
    t = edgeNo + 1;
    pushExp("drain_entry_rearm", t, mk(6'h3f, 3'd6, 1'b1, 1'b0, 1'b0));
    pushSoft(t + 1, 1'b0);
    advanceTo(t + 1 + HOLD + 5 * GAP + 1);
    checkCount("rearm_ack_count", ackCount, 2);

    softReq = 1'b0;
    stepEdge();
    coreIdle = 1'b0;
    softReq  = 1'b1;
    t = edgeNo + 1;
    pushExp("drain_entry_tmo", t, mk(6'h3f, 3'd6, 1'b1, 1'b0, 1'b0));
    if (TmoEn) begin
      pushExp("drain_last", t + TMO - 1, mk(6'h3f, 3'd6, 1'b1, 1'b0, 1'b0));
      pushSoft(t + TMO, 1'b1);
      advanceTo(t + TMO + HOLD + 5 * GAP + 1);
    end else begin
      pushExp("drain_wait", t + 300, mk(6'h3f, 3'd6, 1'b1, 1'b0, 1'b0));
      advanceTo(t + 300);
      coreIdle = 1'b1;
      pushSoft(t + 301, 1'b0);
      advanceTo(t + 301 + HOLD + 5 * GAP + 1);
    end
    checkCount("drain_ack_count", ackCount, 3);

    softReq  = 1'b0;
    coreIdle = 1'b1;
    stepEdge();
    softReq = 1'b1;
    t = edgeNo + 1;
    pushExp("drain_entry_abort", t, mk(6'h3f, 3'd6, 1'b1, 1'b0, 1'b0));
    pushExp("hold_entry_abort", t + 1, mk(6'h01, 3'd6, 1'b1, 1'b0, 1'b0));
    advanceTo(t + 6);
    coreRst = 1'b1;
    softReq = 1'b0;
    #1;
    checkOutput("rst_mid_hold", mk(6'h00, 3'd0, 1'b1, 1'b0, 1'b0));
    @(negedge clock);
    coreRst = 1'b0;
    edgeNo  = 0;
    pushPowerOn();
    advanceTo(30);
    checkCount("hold_abort_no_ack", ackCount, 3);

    softReq = 1'b1;
    t = edgeNo + 1;
    h = t + 1;
    pushExp("drain_entry_abort2", t, mk(6'h3f, 3'd6, 1'b1, 1'b0, 1'b0));
    pushExp("idu_rel_abort2", h + HOLD + 4 * GAP, mk(6'h1f, 3'd5, 1'b1, 1'b0, 1'b0));
    advanceTo(h + HOLD + 5 * GAP - 1);
    coreRst = 1'b1;
    softReq = 1'b0;
    #1;
    checkOutput("rst_mid_release", mk(6'h00, 3'd0, 1'b1, 1'b0, 1'b0));
    @(negedge clock);
    coreRst = 1'b0;
    edgeNo  = 0;
    pushPowerOn();
    advanceTo(30);
    checkCount("release_abort_no_ack", ackCount, 3);

    scanMode = 1'b1;
    scanRstB = 1'b0;
    #1;
    checkOutput("scan_low_run", mk(6'h00, 3'd6, 1'b0, 1'b0, 1'b0));
    scanRstB = 1'b1;
    #1;
    checkOutput("scan_high_run", mk(6'h3f, 3'd6, 1'b0, 1'b0, 1'b0));
    coreIdle = 1'b0;
    softReq  = 1'b1;
    stepEdge();
    scanRstB = 1'b0;
    #1;
    checkOutput("scan_low_drain", mk(6'h00, 3'd6, 1'b1, 1'b0, 1'b0));
    scanRstB = 1'b1;
    #1;
    checkOutput("scan_high_drain", mk(6'h3f, 3'd6, 1'b1, 1'b0, 1'b0));
    coreIdle = 1'b1;
    stepEdge();
    checkOutput("scan_high_hold", mk(6'h3f, 3'd6, 1'b1, 1'b0, 1'b0));
    scanRstB = 1'b0;
    #1;
    checkOutput("scan_low_hold", mk(6'h00, 3'd6, 1'b1, 1'b0, 1'b0));
    scanMode = 1'b0;
    #1;
    checkOutput("scan_off_hold", mk(6'h01, 3'd6, 1'b1, 1'b0, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
